// File: rtl/vending_machine_change.sv
// Parametrised vending controller: collects nickel/dime/quarter credit toward PRICE,
// dispenses once per purchase and pays back any overpay or refund as single-nickel pulses.
module vending_machine_change #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;

    logic [1:0]          coin_count;
    logic                any_coin;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] credit_sum;

    assign coin_count = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
    assign any_coin   = nickel | dime | quarter;
    assign credit_sum = credit_q + coin_value;

    always_comb begin
        coin_value = '0;
        if (nickel) begin
            coin_value = NICKEL_C;
        end else if (dime) begin
            coin_value = DIME_C;
        end else if (quarter) begin
            coin_value = QUARTER_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                // Cancel beats a simultaneous coin: the coin bounces, only prior credit is refunded.
                if (cancel && (state_q == COLLECT)) begin
                    state_d       = CHANGE;
                    coin_reject_d = any_coin;
                end else if (coin_count > 2'd1) begin
                    coin_reject_d = 1'b1;
                end else if (any_coin) begin
                    credit_d = credit_sum;
                    state_d  = (credit_sum >= PRICE_C) ? VEND : COLLECT;
                end
            end
            VEND: begin
                coin_reject_d = any_coin;
                credit_d      = credit_q - PRICE_C;
                state_d       = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                credit_d      = credit_q - NICKEL_C;
                if (credit_q <= NICKEL_C) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign dispense      = (state_q == VEND);
    assign change_nickel = (state_q == CHANGE);
    assign busy          = (state_q == VEND) || (state_q == CHANGE);
    assign coin_reject   = coin_reject_q;
    assign credit        = credit_q;

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench: a PRICE=15 instance walks the purchase/change/cancel/reject/reset cases,
// a PRICE=25 instance covers the larger-price overpay case.
module tb_vending_machine_change;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel, dime, quarter, cancel;
    logic       dispense, change_nickel, coin_reject, busy;
    logic [5:0] credit;

    logic       b_nickel, b_dime, b_quarter, b_cancel;
    logic       b_dispense, b_change_nickel, b_coin_reject, b_busy;
    logic [5:0] b_credit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vending_machine_change #(.PRICE(15), .CREDIT_W(6)) dut (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .dispense(dispense), .change_nickel(change_nickel),
        .coin_reject(coin_reject), .busy(busy), .credit(credit)
    );

    vending_machine_change #(.PRICE(25), .CREDIT_W(6)) dut25 (
        .clk(clk), .reset(reset), .nickel(b_nickel), .dime(b_dime), .quarter(b_quarter),
        .cancel(b_cancel), .dispense(b_dispense), .change_nickel(b_change_nickel),
        .coin_reject(b_coin_reject), .busy(b_busy), .credit(b_credit)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Check the full PRICE=15 output set in one line per step.
    task automatic expect_a(input string tag, input int disp, input int chg,
                            input int rej, input int bsy, input int cred);
        check({tag, ".dispense"},      int'(dispense),      disp);
        check({tag, ".change_nickel"}, int'(change_nickel), chg);
        check({tag, ".coin_reject"},   int'(coin_reject),   rej);
        check({tag, ".busy"},          int'(busy),          bsy);
        check({tag, ".credit"},        int'(credit),        cred);
        $display("%0t %s: dispense=%0b change=%0b reject=%0b busy=%0b credit=%0d",
                 $time, tag, dispense, change_nickel, coin_reject, busy, credit);
    endtask

    task automatic expect_b(input string tag, input int disp, input int chg, input int cred);
        check({tag, ".dispense"},      int'(b_dispense),      disp);
        check({tag, ".change_nickel"}, int'(b_change_nickel), chg);
        check({tag, ".credit"},        int'(b_credit),        cred);
        $display("%0t %s: dispense=%0b change=%0b credit=%0d",
                 $time, tag, b_dispense, b_change_nickel, b_credit);
    endtask

    // Apply one cycle of inputs to the PRICE=15 instance; return 1 time unit after the edge.
    task automatic step_a(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        @(posedge clk); #1;
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    endtask

    task automatic step_b(input logic n, input logic d, input logic q);
        b_nickel = n; b_dime = d; b_quarter = q;
        @(posedge clk); #1;
        b_nickel = 1'b0; b_dime = 1'b0; b_quarter = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
        b_nickel = 1'b0; b_dime = 1'b0; b_quarter = 1'b0; b_cancel = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_a("reset", 0, 0, 0, 0, 0);
        expect_b("reset25", 0, 0, 0);
        reset = 1'b0;

        // 1: three nickels, dispense right after the third, no change
        step_a(1, 0, 0, 0); expect_a("t1.n1", 0, 0, 0, 0, 5);
        step_a(1, 0, 0, 0); expect_a("t1.n2", 0, 0, 0, 0, 10);
        step_a(1, 0, 0, 0); expect_a("t1.vend", 1, 0, 0, 1, 15);
        step_a(0, 0, 0, 0); expect_a("t1.idle", 0, 0, 0, 0, 0);

        // 2: quarter, vend at 25, then two change nickels
        step_a(0, 0, 1, 0); expect_a("t2.vend", 1, 0, 0, 1, 25);
        step_a(0, 0, 0, 0); expect_a("t2.chg1", 0, 1, 0, 1, 10);
        step_a(0, 0, 0, 0); expect_a("t2.chg2", 0, 1, 0, 1, 5);
        step_a(0, 0, 0, 0); expect_a("t2.idle", 0, 0, 0, 0, 0);

        // 3: double coin rejected, then dime + cancel refunds two nickels
        step_a(1, 1, 0, 0); expect_a("t3.multi", 0, 0, 1, 0, 0);
        step_a(0, 0, 0, 0); expect_a("t3.clear", 0, 0, 0, 0, 0);
        step_a(1, 1, 1, 0); expect_a("t3.triple", 0, 0, 1, 0, 0);
        step_a(0, 1, 0, 0); expect_a("t3.dime", 0, 0, 0, 0, 10);
        step_a(0, 0, 0, 1); expect_a("t3.cancel", 0, 1, 0, 1, 10);
        step_a(0, 0, 0, 0); expect_a("t3.chg2", 0, 1, 0, 1, 5);
        step_a(0, 0, 0, 0); expect_a("t3.idle", 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 1); expect_a("t3.idle_cancel", 0, 0, 0, 0, 0);

        // 4: coin during CHANGE bounces; cancel+dime in COLLECT refunds prior nickel only
        step_a(0, 0, 1, 0); expect_a("t4.vend", 1, 0, 0, 1, 25);
        step_a(0, 0, 0, 0); expect_a("t4.chg1", 0, 1, 0, 1, 10);
        step_a(1, 0, 0, 0); expect_a("t4.coin_in_chg", 0, 1, 1, 1, 5);
        step_a(0, 0, 0, 0); expect_a("t4.idle", 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0); expect_a("t4.nickel", 0, 0, 0, 0, 5);
        step_a(0, 1, 0, 1); expect_a("t4.cancel_dime", 0, 1, 1, 1, 5);
        step_a(0, 0, 0, 0); expect_a("t4.idle2", 0, 0, 0, 0, 0);

        // 5: reset in first CHANGE cycle discards change; machine then vends normally
        step_a(0, 0, 1, 0); expect_a("t5.vend", 1, 0, 0, 1, 25);
        step_a(0, 0, 0, 0); expect_a("t5.chg1", 0, 1, 0, 1, 10);
        reset = 1'b1;
        step_a(1, 0, 0, 0); expect_a("t5.reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step_a(1, 0, 0, 0); expect_a("t5.n1", 0, 0, 0, 0, 5);
        step_a(1, 0, 0, 0); expect_a("t5.n2", 0, 0, 0, 0, 10);
        step_a(1, 0, 0, 0); expect_a("t5.vend2", 1, 0, 0, 1, 15);
        step_a(0, 0, 0, 0); expect_a("t5.idle", 0, 0, 0, 0, 0);

        // 6: PRICE=25, dime,dime,quarter -> vend at 45, four change nickels
        step_b(0, 1, 0); expect_b("t6.d1", 0, 0, 10);
        step_b(0, 1, 0); expect_b("t6.d2", 0, 0, 20);
        step_b(0, 0, 1); expect_b("t6.vend", 1, 0, 45);
        check("t6.busy", int'(b_busy), 1);
        step_b(0, 0, 0); expect_b("t6.chg1", 0, 1, 20);
        step_b(0, 0, 0); expect_b("t6.chg2", 0, 1, 15);
        step_b(0, 0, 0); expect_b("t6.chg3", 0, 1, 10);
        step_b(0, 0, 0); expect_b("t6.chg4", 0, 1, 5);
        step_b(0, 0, 0); expect_b("t6.idle", 0, 0, 0);
        check("t6.reject", int'(b_coin_reject), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
